// File: rtl/veda_memory_burst_if.sv
// ---------------------------------------------------------------------------
// veda_memory_burst_if
//   Request / write-beat / read-beat bundle for veda_memory_burst.
//
//   Request channel : req_valid, req_ready, req_write, req_addr, req_len
//   Write channel   : wr_valid, wr_ready, wr_data, wr_strb
//   Read channel    : rd_valid, rd_ready, rd_data, rd_last
//   Status          : busy
//
//   master : the requester (datapath / DMA / testbench)
//   slave  : the memory
// ---------------------------------------------------------------------------
interface veda_memory_burst_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 4
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STRB_W = DATA_W / 8;

  // request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  // write beat channel
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  // read beat channel
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  // status
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wr_valid, wr_data, wr_strb,
    output rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_valid, wr_data, wr_strb,
    input  rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/veda_memory_burst.sv
// ---------------------------------------------------------------------------
// veda_memory_burst
//   Single-port on-chip word memory with per-byte write strobes and a
//   valid/ready burst interface. A request carries a start address and a
//   beat count minus one; the burst then auto-increments the word pointer,
//   wrapping from DEPTH-1 back to 0.
//
//   Ports
//     clk    : single clock, all state changes on the rising edge
//     reset  : synchronous, active-high; clears every word and aborts any
//              burst in progress
//     bus    : veda_memory_burst_if.slave
//              req_*  : burst request (accepted only in IDLE)
//              wr_*   : write beats, byte-enabled by wr_strb
//              rd_*   : read beats, 1-cycle latency, 1 beat/cycle,
//                       rd_last flags the final beat
//              busy   : high while a burst is in progress
//
//   Parameters
//     DATA_W : word width in bits (multiple of 8)
//     DEPTH  : number of words (power of 2)
//     LEN_W  : burst length field width; a burst is req_len+1 beats
// ---------------------------------------------------------------------------
module veda_memory_burst #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  veda_memory_burst_if.slave  bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [LEN_W-1:0]  beats_left_reg, beats_left_next;
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              rd_last_reg, rd_last_next;

  // Storage is a plain register array: the whole memory must clear in the
  // single reset cycle, which a block RAM cannot do.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  // -------------------------------------------------------------------------
  // Handshakes and status
  // -------------------------------------------------------------------------
  logic              req_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic [ADDR_W-1:0] ptr_inc;
  logic [STRB_W-1:0] byte_we;

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.wr_ready  = (state_reg == WRITE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_last   = rd_last_reg;

  assign req_fire = bus.req_valid && bus.req_ready;
  assign wr_fire  = bus.wr_valid  && bus.wr_ready;
  assign rd_fire  = rd_valid_reg  && bus.rd_ready;

  // ADDR_W-bit addition wraps naturally at DEPTH because DEPTH is 2^ADDR_W.
  assign ptr_inc = ptr_reg + 1'b1;

  // Per-byte write enables for the word addressed by ptr_reg.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte_we
      assign byte_we[gi] = wr_fire && bus.wr_strb[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM state register and read-output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      beats_left_reg <= '0;
      rd_data_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      beats_left_reg <= beats_left_next;
      rd_data_reg    <= rd_data_next;
      rd_valid_reg   <= rd_valid_next;
      rd_last_reg    <= rd_last_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    beats_left_next = beats_left_reg;
    rd_data_next    = rd_data_reg;
    rd_valid_next   = rd_valid_reg;
    rd_last_next    = rd_last_reg;

    unique case (state_reg)
      IDLE: begin
        if (req_fire) begin
          ptr_next        = bus.req_addr;
          beats_left_next = bus.req_len;
          if (bus.req_write) begin
            state_next = WRITE;
          end else begin
            // First read beat is fetched on the accepting edge so that it
            // is presented one cycle after the request.
            state_next    = READ;
            rd_data_next  = mem_reg[bus.req_addr];
            rd_valid_next = 1'b1;
            rd_last_next  = (bus.req_len == '0);
          end
        end
      end

      WRITE: begin
        if (wr_fire) begin
          ptr_next        = ptr_inc;
          beats_left_next = beats_left_reg - 1'b1;
          if (beats_left_reg == '0) begin
            state_next = IDLE;
          end
        end
      end

      READ: begin
        if (rd_fire) begin
          if (rd_last_reg) begin
            // rd_data intentionally keeps the final beat.
            state_next    = IDLE;
            rd_valid_next = 1'b0;
            rd_last_next  = 1'b0;
          end else begin
            ptr_next        = ptr_inc;
            beats_left_next = beats_left_reg - 1'b1;
            rd_data_next    = mem_reg[ptr_inc];
            // beats_left_next == 0 exactly when the current count is 1.
            rd_last_next    = (beats_left_reg == LEN_W'(1));
          end
        end
        // Without a handshake all read outputs hold.
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory array: full clear on reset, byte-masked write otherwise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_reg[w] <= '0;
      end
    end else begin
      for (int k = 0; k < STRB_W; k++) begin
        if (byte_we[k]) begin
          mem_reg[ptr_reg][8*k +: 8] <= bus.wr_data[8*k +: 8];
        end
      end
    end
  end

endmodule
